// File: rtl/alu_pkg.sv
// alu_pkg: ALU control encoding shared by the ALU core and its users
package alu_pkg;
  typedef enum logic [3:0] {
    OP_AND    = 4'b0000,
    OP_OR     = 4'b0001,
    OP_ADD    = 4'b0010,
    OP_SLL    = 4'b0011,
    OP_SRL    = 4'b0100,
    ILLEGAL_5 = 4'b0101,
    OP_SUB    = 4'b0110,
    OP_SLT    = 4'b0111,
    OP_ADDU   = 4'b1000,
    OP_SUBU   = 4'b1001,
    OP_XOR    = 4'b1010,
    OP_SLTU   = 4'b1011,
    OP_NOR    = 4'b1100,
    OP_SRA    = 4'b1101,
    OP_LUI    = 4'b1110,
    RTYPE     = 4'b1111
  } alu_op_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return !(op == ILLEGAL_5 || op == RTYPE);
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU on the 4-bit control encoding
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             err
);
  logic [WIDTH-1:0] sum, diff;
  logic [4:0] sh;
  assign sum  = a + b;
  assign diff = a - b;
  assign sh   = a[4:0];
  always_comb begin
    result = '0;
    ovf = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_ADD:  begin result = sum; ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]); end
      OP_SUB:  begin result = diff; ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]); end
      OP_ADDU: result = sum;
      OP_SUBU: result = diff;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  result = b << sh;
      OP_SRL:  result = b >> sh;
      OP_SRA:  result = $signed(b) >>> sh;
      OP_LUI:  result = b << 16;
      default: result = '0;
    endcase
  end
  assign err  = !is_legal_op(op);
  assign zero = result == '0;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_ovf,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_ovf,
  output logic             rsp1_err
);
  logic elig0, elig1, gnt0, gnt1, last_grant;
  logic [3:0] op;
  logic [WIDTH-1:0] a, b, result;
  logic zero, ovf, err;
  // a full buffer being drained this cycle can accept a new result
  assign elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
  assign elig1 = req1_valid && (!rsp1_valid || rsp1_ready);
  assign gnt0 = rst_n && elig0 && (!elig1 || last_grant);
  assign gnt1 = rst_n && elig1 && (!elig0 || !last_grant);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign op = gnt1 ? req1_op : req0_op;
  assign a  = gnt1 ? req1_a : req0_a;
  assign b  = gnt1 ? req1_b : req0_b;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op(op),
    .a(a),
    .b(b),
    .result(result),
    .zero(zero),
    .ovf(ovf),
    .err(err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero <= 1'b0;
      rsp0_ovf <= 1'b0;
      rsp0_err <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero <= 1'b0;
      rsp1_ovf <= 1'b0;
      rsp1_err <= 1'b0;
    end else begin
      if (gnt0 || gnt1) last_grant <= gnt1;
      if (gnt0) begin
        rsp0_valid <= 1'b1;
        rsp0_result <= result;
        rsp0_zero <= zero;
        rsp0_ovf <= ovf;
        rsp0_err <= err;
      end else if (rsp0_ready) rsp0_valid <= 1'b0;
      if (gnt1) begin
        rsp1_valid <= 1'b1;
        rsp1_result <= result;
        rsp1_zero <= zero;
        rsp1_ovf <= ovf;
        rsp1_err <= err;
      end else if (rsp1_ready) rsp1_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus checked against a behavioural model
module tb_alu_share_arbiter;
  typedef struct packed {
    logic [31:0] r;
    logic z, o, e;
  } res_t;
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic o, e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0, rsp_ready = '0;
  logic [3:0] op [2];
  logic [31:0] a [2], b [2];
  wire [1:0] req_ready, rsp_valid, rsp_zero, rsp_ovf, rsp_err;
  wire [31:0] res [2];

  int total = 0, bad = 0;
  bit armed = 1'b0;
  logic [1:0] m_valid = '0;
  logic m_last = 1'b1;
  res_t m_rsp [2];

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op(op[0]), .req0_a(a[0]), .req0_b(b[0]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_result(res[0]),
    .rsp0_zero(rsp_zero[0]), .rsp0_ovf(rsp_ovf[0]), .rsp0_err(rsp_err[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op(op[1]), .req1_a(a[1]), .req1_b(b[1]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_result(res[1]),
    .rsp1_zero(rsp_zero[1]), .rsp1_ovf(rsp_ovf[1]), .rsp1_err(rsp_err[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference ALU computed with 64-bit arithmetic rather than sign-bit rules
  function automatic res_t ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t q;
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q = '0;
    case (o)
      4'b0000: q.r = x & y;
      4'b0001: q.r = x | y;
      4'b0010: begin s = sx + sy; q.r = s[31:0]; q.o = s != longint'($signed(q.r)); end
      4'b0011: q.r = y << x[4:0];
      4'b0100: q.r = y >> x[4:0];
      4'b0110: begin s = sx - sy; q.r = s[31:0]; q.o = s != longint'($signed(q.r)); end
      4'b0111: q.r = (sx < sy) ? 32'd1 : 32'd0;
      4'b1000: q.r = x + y;
      4'b1001: q.r = x - y;
      4'b1010: q.r = x ^ y;
      4'b1011: q.r = (x < y) ? 32'd1 : 32'd0;
      4'b1100: q.r = ~(x | y);
      4'b1101: begin s = sy >>> x[4:0]; q.r = s[31:0]; end
      4'b1110: begin s = longint'(y) * 65536; q.r = s[31:0]; end
      default: q.e = 1'b1;
    endcase
    q.z = q.r == 32'd0;
    return q;
  endfunction

  // who should win this cycle: -1 none, else port index
  function automatic int exp_grant();
    bit e0, e1;
    if (!rst_n) return -1;
    e0 = req_valid[0] && (!m_valid[0] || rsp_ready[0]);
    e1 = req_valid[1] && (!m_valid[1] || rsp_ready[1]);
    if (e0 && e1) return m_last ? 0 : 1;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      armed <= 1'b1;
      m_valid <= '0;
      m_last <= 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (exp_grant() == p) begin
          m_valid[p] <= 1'b1;
          m_rsp[p] <= ref_alu(op[p], a[p], b[p]);
          m_last <= p[0];
        end else if (rsp_ready[p]) m_valid[p] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      int g;
      g = exp_grant();
      chk("req_ready", 32'(req_ready), g < 0 ? 32'd0 : (g == 0 ? 32'd1 : 32'd2));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      for (int p = 0; p < 2; p++) begin
        if (m_valid[p]) begin
          chk("rsp_result", res[p], m_rsp[p].r);
          chk("rsp_zero", 32'(rsp_zero[p]), 32'(m_rsp[p].z));
          chk("rsp_ovf", 32'(rsp_ovf[p]), 32'(m_rsp[p].o));
          chk("rsp_err", 32'(rsp_err[p]), 32'(m_rsp[p].e));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op[p] = o;
    a[p] = x;
    b[p] = y;
  endtask

  initial begin
    res_t q;
    vec_t vt [$];
    vt = '{
      '{4'b0010, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b1, 1'b0},
      '{4'b1000, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b0},
      '{4'b0111, 32'hffffffff, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
      '{4'b1011, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b0, 1'b0},
      '{4'b1101, 32'h00000004, 32'h80000000, 32'hf8000000, 1'b0, 1'b0},
      '{4'b1110, 32'h00000000, 32'h00001234, 32'h12340000, 1'b0, 1'b0},
      '{4'b0110, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1, 1'b0},
      '{4'b1001, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b0, 1'b0},
      '{4'b0100, 32'h00000004, 32'h80000000, 32'h08000000, 1'b0, 1'b0},
      '{4'b0011, 32'h00000001, 32'h00000003, 32'h00000006, 1'b0, 1'b0},
      '{4'b1100, 32'h00000000, 32'h00000000, 32'hffffffff, 1'b0, 1'b0},
      '{4'b1010, 32'h0000f0f0, 32'h0000ff00, 32'h00000ff0, 1'b0, 1'b0},
      '{4'b0000, 32'h0000000c, 32'h00000006, 32'h00000004, 1'b0, 1'b0},
      '{4'b0001, 32'h0000000c, 32'h00000003, 32'h0000000f, 1'b0, 1'b0},
      '{4'b0101, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0, 1'b1},
      '{4'b0010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0}
    };
    for (int p = 0; p < 2; p++) put(p, 4'b0000, 32'd0, 32'd0);
    q = ref_alu(4'b0010, 32'd5, 32'd7);
    chk("model_add", q.r, 32'd12);
    q = ref_alu(4'b0010, 32'h7fffffff, 32'd1);
    chk("model_add_ovf", 32'(q.o), 32'd1);
    q = ref_alu(4'b1101, 32'd4, 32'h80000000);
    chk("model_sra", q.r, 32'hf8000000);
    q = ref_alu(4'b1111, 32'd9, 32'd9);
    chk("model_illegal", {q.r[30:0], q.e}, 32'd1);
    // reset with both requests asserted: nothing may be granted
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    cyc();
    cyc();
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_result", res[0] | res[1], 32'd0);
    chk("reset_flags", 32'({rsp_zero, rsp_ovf, rsp_err}), 32'd0);
    cyc();
    rst_n = 1'b1;
    req_valid = 2'b01;
    put(0, 4'b0010, 32'd5, 32'd7);
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid[0]), 32'd1);
    chk("single_result", res[0], 32'd12);
    chk("single_flags", 32'({rsp_zero[0], rsp_ovf[0], rsp_err[0]}), 32'd0);
    cyc();
    // contention: port 0 won last, so port 1 takes the first tie
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      put(0, 4'b0010, 32'(i), 32'd1);
      put(1, 4'b0001, 32'(i), 32'd16);
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), (i % 2 == 0) ? 32'd2 : 32'd1);
      cyc();
    end
    req_valid = 2'b00;
    cyc();
    // backpressure on port 1 while port 0 keeps flowing
    req_valid = 2'b10;
    rsp_ready = 2'b01;
    put(1, 4'b0110, 32'd3, 32'd3);
    cyc();
    req_valid = 2'b11;
    put(1, 4'b0010, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      put(0, 4'b0010, 32'(i), 32'd2);
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 32'd1);
      chk("bp_hold", res[1], 32'd0);
      chk("bp_zero", 32'({rsp_valid[1], rsp_zero[1]}), 32'd3);
      cyc();
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("drain_grant", 32'(req_ready), 32'd2);
    cyc();
    req_valid = 2'b00;
    @(negedge clk);
    chk("refill_valid", 32'(rsp_valid[1]), 32'd1);
    chk("refill_result", res[1], 32'd2);
    cyc();
    foreach (vt[i]) begin
      req_valid = 2'b01;
      put(0, vt[i].op, vt[i].a, vt[i].b);
      cyc();
      req_valid = 2'b00;
      @(negedge clk);
      chk("vec_result", res[0], vt[i].r);
      chk("vec_flags", 32'({rsp_ovf[0], rsp_err[0]}), 32'({vt[i].o, vt[i].e}));
      cyc();
    end
    req_valid = 2'b10;
    put(1, 4'b1111, 32'h55, 32'h66);
    cyc();
    req_valid = 2'b00;
    @(negedge clk);
    chk("illegal_result", res[1], 32'd0);
    chk("illegal_flags", 32'({rsp_valid[1], rsp_zero[1], rsp_ovf[1], rsp_err[1]}), 32'b1101);
    cyc();
    // reset while a response is held and both ports are requesting
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    put(0, 4'b0010, 32'd1, 32'd2);
    cyc();
    req_valid = 2'b11;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_held", 32'(rsp_valid), 32'd1);
    cyc();
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("postrst_valid", 32'(rsp_valid), 32'd0);
    chk("postrst_tie", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 2'b00;
    @(negedge clk);
    chk("postrst_rsp", 32'(rsp_valid), 32'd1);
    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
